// File: rtl/light_mon_pkg.sv
// Shared lamp codes, fault codes and monitor state encoding for light_monitor.
package light_mon_pkg;

    localparam int unsigned LAMP_W  = 2;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned N_LAMPS = 4;

    typedef enum logic [LAMP_W-1:0] {
        LAMP_R   = 2'b00,
        LAMP_Y   = 2'b01,
        LAMP_G   = 2'b10,
        LAMP_BAD = 2'b11
    } lamp_t;

    typedef enum logic [CODE_W-1:0] {
        FC_NONE     = 3'd0,
        FC_INVALID  = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_G_TO_R   = 3'd3,
        FC_SHORT_Y  = 3'd4,
        FC_STUCK_G  = 3'd5
    } fault_code_t;

    typedef enum logic [1:0] {
        MON_INIT  = 2'd0,
        MON_RUN   = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_t;

endpackage

// File: rtl/lamp_dwell.sv
// Per-lamp history: previous sampled code and saturating seconds-since-change count.
module lamp_dwell
    import light_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LAMP_W-1:0] lamp,
    input  logic              tick_1s,
    output logic [LAMP_W-1:0] prev,
    output logic [CNT_W-1:0]  dwell
);

    localparam logic [CNT_W-1:0] DWELL_MAX = '1;

    // Track last code; dwell restarts on any change and counts ticks while steady.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= LAMP_Y;
            dwell <= '0;
        end else begin
            prev <= lamp;
            if (lamp != prev) begin
                dwell <= '0;
            end else if (tick_1s && (dwell != DWELL_MAX)) begin
                dwell <= dwell + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/light_monitor.sv
// Traffic-light safety monitor: checks four lamp codes for illegal states and
// sequences, latches the first fault cause and requests all-yellow flashing.
// Define LIGHT_MON_WATCHDOG_EN to enable the green-stuck watchdog (fault code 5).
module light_monitor
    import light_mon_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 1,
    parameter int unsigned MAX_GREEN  = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LAMP_W-1:0] light_west,
    input  logic [LAMP_W-1:0] light_east,
    input  logic [LAMP_W-1:0] light_north,
    input  logic [LAMP_W-1:0] light_south,
    input  logic              tick_1s,
    input  logic              clear_fault,
    output logic              fault,
    output logic [CODE_W-1:0] fault_code,
    output logic              force_flash,
    output logic              armed
);

    localparam int unsigned      DWELL_SAT = (32'd1 << CNT_W) - 32'd1;
    localparam logic [CNT_W-1:0] MIN_Y     = CNT_W'(MIN_YELLOW);

    // Thresholds must stay below the counter saturation value.
    if ((MIN_YELLOW >= DWELL_SAT) || (MAX_GREEN >= DWELL_SAT)) begin : g_param_check
        $error("light_monitor: MIN_YELLOW/MAX_GREEN must be below 2^CNT_W-1");
    end

    logic [LAMP_W-1:0] lamp  [N_LAMPS];
    logic [LAMP_W-1:0] prev  [N_LAMPS];
    logic [CNT_W-1:0]  dwell [N_LAMPS];

    assign lamp[0] = light_west;
    assign lamp[1] = light_east;
    assign lamp[2] = light_north;
    assign lamp[3] = light_south;

    for (genvar i = 0; i < N_LAMPS; i++) begin : g_lamp
        lamp_dwell #(.CNT_W(CNT_W)) u_dwell (
            .clk     (clk),
            .rst     (rst),
            .lamp    (lamp[i]),
            .tick_1s (tick_1s),
            .prev    (prev[i]),
            .dwell   (dwell[i])
        );
    end

    mon_state_t  state;
    logic        bad_c;
    logic        conflict_c;
    logic        g_to_r_c;
    logic        short_y_c;
    logic        all_y_c;
    logic [2:0]  g_cnt_c;
    fault_code_t init_code_c;
    fault_code_t run_code_c;
`ifdef LIGHT_MON_WATCHDOG_EN
    localparam logic [CNT_W-1:0] MAX_G = CNT_W'(MAX_GREEN);
    logic        stuck_c;
`endif

    // Evaluate every check on the current sample; lowest code wins.
    always_comb begin
        bad_c     = 1'b0;
        g_to_r_c  = 1'b0;
        short_y_c = 1'b0;
        all_y_c   = 1'b1;
        g_cnt_c   = 3'd0;
`ifdef LIGHT_MON_WATCHDOG_EN
        stuck_c   = 1'b0;
`endif
        for (int i = 0; i < N_LAMPS; i++) begin
            if (lamp[i] == LAMP_BAD) bad_c = 1'b1;
            if (lamp[i] == LAMP_G) g_cnt_c = g_cnt_c + 3'd1;
            if (lamp[i] != LAMP_Y) all_y_c = 1'b0;
            if ((prev[i] == LAMP_G) && (lamp[i] == LAMP_R)) g_to_r_c = 1'b1;
            if ((prev[i] == LAMP_Y) && (lamp[i] == LAMP_R) && (dwell[i] < MIN_Y)) short_y_c = 1'b1;
`ifdef LIGHT_MON_WATCHDOG_EN
            if ((prev[i] == LAMP_G) && (lamp[i] == LAMP_G) && tick_1s && (dwell[i] == MAX_G)) stuck_c = 1'b1;
`endif
        end
        conflict_c = (g_cnt_c > 3'd1);

        init_code_c = FC_NONE;
        if (conflict_c) init_code_c = FC_CONFLICT;
        if (bad_c)      init_code_c = FC_INVALID;

        run_code_c = FC_NONE;
`ifdef LIGHT_MON_WATCHDOG_EN
        if (stuck_c)    run_code_c = FC_STUCK_G;
`endif
        if (short_y_c)  run_code_c = FC_SHORT_Y;
        if (g_to_r_c)   run_code_c = FC_G_TO_R;
        if (conflict_c) run_code_c = FC_CONFLICT;
        if (bad_c)      run_code_c = FC_INVALID;
    end

    // Monitor FSM with registered fault/flash/armed outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MON_INIT;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            force_flash <= 1'b0;
            armed       <= 1'b0;
        end else begin
            case (state)
                MON_INIT: begin
                    if (init_code_c != FC_NONE) begin
                        state       <= MON_FAULT;
                        fault       <= 1'b1;
                        force_flash <= 1'b1;
                        fault_code  <= init_code_c;
                    end else if (all_y_c) begin
                        state <= MON_RUN;
                        armed <= 1'b1;
                    end
                end
                MON_RUN: begin
                    if (run_code_c != FC_NONE) begin
                        state       <= MON_FAULT;
                        fault       <= 1'b1;
                        force_flash <= 1'b1;
                        fault_code  <= run_code_c;
                        armed       <= 1'b0;
                    end
                end
                MON_FAULT: begin
                    if (clear_fault) begin
                        state       <= MON_INIT;
                        fault       <= 1'b0;
                        force_flash <= 1'b0;
                        fault_code  <= FC_NONE;
                    end
                end
                default: begin
                    state       <= MON_INIT;
                    fault       <= 1'b0;
                    force_flash <= 1'b0;
                    fault_code  <= FC_NONE;
                    armed       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_monitor.sv
// Self-checking bench for light_monitor: behavioural model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_light_monitor;

    localparam int unsigned MIN_Y = 2;
    localparam int unsigned MAX_G = 8;
    localparam int unsigned CW    = 4;
    localparam int          SAT   = (1 << CW) - 1;

    localparam logic [1:0] R  = 2'b00;
    localparam logic [1:0] Y  = 2'b01;
    localparam logic [1:0] G  = 2'b10;
    localparam logic [1:0] XX = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] lw = Y, le = Y, ln = Y, ls = Y;
    logic       tick = 1'b0;
    logic       clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic       force_flash;
    logic       armed;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    light_monitor #(.MIN_YELLOW(MIN_Y), .MAX_GREEN(MAX_G), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .light_west  (lw),
        .light_east  (le),
        .light_north (ln),
        .light_south (ls),
        .tick_1s     (tick),
        .clear_fault (clr),
        .fault       (fault),
        .fault_code  (fault_code),
        .force_flash (force_flash),
        .armed       (armed)
    );

    // Model: mode 0 = waiting for idle frame, 1 = watching, 2 = latched fault.
    bit mvalid = 1'b0;
    int m_mode = 0;
    int m_code = 0;
    int m_last [4];
    int m_secs [4];

    function automatic int first_violation(input int cur [4], input bit running, input bit t);
        int ng = 0;
        bit hit [6];
        for (int k = 0; k < 6; k++) hit[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cur[i] == 3) hit[1] = 1'b1;
            if (cur[i] == 2) ng++;
            if (m_last[i] == 2 && cur[i] == 0) hit[3] = 1'b1;
            if (m_last[i] == 1 && cur[i] == 0 && m_secs[i] < int'(MIN_Y)) hit[4] = 1'b1;
`ifdef LIGHT_MON_WATCHDOG_EN
            if (m_last[i] == 2 && cur[i] == 2 && t && m_secs[i] == int'(MAX_G)) hit[5] = 1'b1;
`endif
        end
        if (ng > 1) hit[2] = 1'b1;
        for (int c = 1; c <= 5; c++)
            if (hit[c] && (c <= 2 || running)) return c;
        return 0;
    endfunction

    always @(posedge clk) begin : p_model
        int cur [4];
        int v;
        bit ally;
        cur[0] = int'(lw); cur[1] = int'(le); cur[2] = int'(ln); cur[3] = int'(ls);
        if (rst) begin
            mvalid = 1'b1;
            m_mode = 0;
            m_code = 0;
            for (int i = 0; i < 4; i++) begin m_last[i] = 1; m_secs[i] = 0; end
        end else begin
            v = first_violation(cur, m_mode == 1, tick);
            ally = (cur[0] == 1) && (cur[1] == 1) && (cur[2] == 1) && (cur[3] == 1);
            if (m_mode == 2) begin
                if (clr) begin m_mode = 0; m_code = 0; end
            end else if (v != 0) begin
                m_mode = 2; m_code = v;
            end else if (m_mode == 0 && ally) begin
                m_mode = 1;
            end
            for (int i = 0; i < 4; i++) begin
                if (cur[i] != m_last[i]) m_secs[i] = 0;
                else if (tick && m_secs[i] < SAT) m_secs[i]++;
                m_last[i] = cur[i];
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            logic ef;
            logic ea;
            ef = (m_mode == 2);
            ea = (m_mode == 1);
            tests++;
            if (fault !== ef || fault_code !== 3'(m_code) || force_flash !== ef || armed !== ea) begin
                fails++;
                $display("FAIL model_cycle t=%0t fault=%b want %b code=%0d want %0d flash=%b want %b armed=%b want %b",
                         $time, fault, ef, fault_code, m_code, force_flash, ef, armed, ea);
            end
        end
    end

    task automatic step(input logic [1:0] w, e, n, s, input logic t, c);
        lw = w; le = e; ln = n; ls = s; tick = t; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic f, input logic [2:0] c, input logic a);
        tests++;
        if (fault !== f || fault_code !== c || force_flash !== f || armed !== a) begin
            fails++;
            $display("FAIL %s fault=%b want %b code=%0d want %0d flash=%b want %b armed=%b want %b",
                     name, fault, f, fault_code, c, force_flash, f, armed, a);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(Y, Y, Y, Y, 0, 0);
        step(Y, Y, Y, Y, 0, 0);
        pin("reset", 0, 3'd0, 0);
        rst = 1'b0;

        // Idle frame arms the monitor; legal west-green phase stays clean
        step(Y, Y, Y, Y, 1, 0);
        pin("arm_on_idle", 0, 3'd0, 1);
        step(Y, Y, Y, Y, 1, 0);
        step(G, R, R, R, 1, 0);
        for (int i = 0; i < 5; i++) step(G, R, R, R, 1, 0);
        pin("west_green_5_ticks", 0, 3'd0, 1);

        // Green conflict, then a later violation must not overwrite the code
        step(G, R, G, R, 0, 0);
        pin("green_conflict", 1, 3'd2, 0);
        step(XX, R, G, R, 0, 0);
        pin("code_held", 1, 3'd2, 0);
        step(Y, Y, Y, Y, 0, 1);
        pin("clear_to_init", 0, 3'd0, 0);

        // Green straight to red
        step(Y, Y, Y, Y, 1, 0);
        step(Y, Y, Y, Y, 1, 0);
        step(R, G, R, R, 0, 0);
        pin("y_to_g_legal", 0, 3'd0, 1);
        step(R, R, R, R, 0, 0);
        pin("g_to_r", 1, 3'd3, 0);
        step(R, R, R, R, 0, 1);
        pin("clear_after_g_to_r", 0, 3'd0, 0);
        step(R, R, R, R, 0, 0);
        pin("init_waits", 0, 3'd0, 0);

        // Init-state checks and re-fault after clear while violation persists
        step(G, G, R, R, 0, 0);
        pin("init_conflict", 1, 3'd2, 0);
        step(G, G, R, R, 0, 1);
        pin("clear_persist", 0, 3'd0, 0);
        step(G, G, R, R, 0, 0);
        pin("refault", 1, 3'd2, 0);
        step(G, R, R, R, 0, 1);
        step(R, R, R, R, 0, 0);
        pin("init_ignores_g_to_r", 0, 3'd0, 0);

        // Short yellow: one tick is below MIN_Y=2
        step(Y, Y, Y, Y, 1, 0);
        step(Y, Y, Y, Y, 1, 0);
        step(Y, Y, Y, Y, 1, 0);
        step(R, R, R, R, 0, 0);
        step(Y, R, R, R, 0, 0);
        step(Y, R, R, R, 1, 0);
        step(R, R, R, R, 0, 0);
        pin("short_yellow", 1, 3'd4, 0);
        step(R, R, R, R, 0, 1);

        // Yellow held two ticks is legal
        step(Y, Y, Y, Y, 1, 0);
        step(Y, Y, Y, Y, 1, 0);
        step(Y, Y, Y, Y, 1, 0);
        step(R, R, R, R, 0, 0);
        step(Y, R, R, R, 0, 0);
        step(Y, R, R, R, 1, 0);
        step(Y, R, R, R, 1, 0);
        step(R, R, R, R, 0, 0);
        pin("yellow_2_ticks_ok", 0, 3'd0, 1);

        // Green watchdog: 8 ticks fine, 9th tick trips only when enabled
        step(R, R, R, G, 0, 0);
        for (int i = 0; i < 8; i++) step(R, R, R, G, 1, 0);
        pin("green_8_ticks", 0, 3'd0, 1);
        step(R, R, R, G, 1, 0);
`ifdef LIGHT_MON_WATCHDOG_EN
        pin("green_9th_tick", 1, 3'd5, 0);
`else
        pin("green_9th_tick", 0, 3'd0, 1);
`endif

        // Invalid code beats simultaneous conflict; reset clears a latched fault
        rst = 1'b1;
        step(Y, Y, Y, Y, 0, 0);
        rst = 1'b0;
        step(Y, Y, Y, Y, 1, 0);
        step(Y, Y, Y, Y, 1, 0);
        step(Y, Y, Y, Y, 1, 0);
        step(XX, G, G, R, 0, 0);
        pin("invalid_beats_conflict", 1, 3'd1, 0);
        rst = 1'b1;
        step(XX, G, G, R, 1, 1);
        pin("reset_mid_fault", 0, 3'd0, 0);
        rst = 1'b0;
        step(XX, R, R, R, 0, 0);
        pin("init_invalid", 1, 3'd1, 0);
        step(Y, Y, Y, Y, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 1, minimum legal yellow dwell in 1 s ticks.
REQ-002 Parameter MAX_GREEN, default 8, maximum legal green dwell in 1 s ticks (watchdog only).
REQ-003 Parameter CNT_W, default 4, dwell counter width; MIN_YELLOW and MAX_GREEN SHALL be < 2^CNT_W-1.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset; synchronous, active-high.
REQ-006 Port: light_west, light_east, light_north, light_south  in  2 each  lamp codes R=00, Y=01, G=10, 11 invalid.
REQ-007 Port: tick_1s  in  1  one-cycle strobe, once per second.
REQ-008 Port: clear_fault  in  1  one-cycle fault acknowledge.
REQ-009 Port: fault  out  1  latched fault flag.
REQ-010 Port: fault_code  out  3  latched cause (0 none, 1 invalid code, 2 green conflict, 3 G->R without Y, 4 short yellow, 5 green stuck).
REQ-011 Port: force_flash  out  1  request to drive all lamps yellow; equals fault.
REQ-012 Port: armed  out  1  high while in MON_RUN.

Function
REQ-013 States SHALL be MON_INIT, MON_RUN, MON_FAULT; all transitions on clk edge.
REQ-014 MON_INIT -> MON_RUN when all four lamps sample Y (controller idle frame); otherwise stay.
REQ-015 In MON_INIT only checks 1 and 2 SHALL be active; in MON_RUN checks 1-5 SHALL be active.
REQ-016 Check 1: any lamp == 11. Check 2: more than one lamp == G in the same cycle.
REQ-017 Check 3: a lamp changes G -> R between consecutive samples.
REQ-018 Check 4: a lamp changes Y -> R with its dwell count < MIN_YELLOW.
REQ-019 Check 5: a lamp is G, unchanged, tick_1s high, and dwell == MAX_GREEN.
REQ-020 Dwell count per lamp SHALL clear to 0 on any code change and increment on tick_1s when unchanged, saturating at 2^CNT_W-1.
REQ-021 Any active check true -> MON_FAULT; fault, force_flash and fault_code registered, visible one cycle after the offending sample.
REQ-022 Simultaneous checks: lowest fault code SHALL win.
REQ-023 MON_FAULT holds fault_code stable; new violations SHALL NOT overwrite it.
REQ-024 clear_fault in MON_FAULT -> MON_INIT, fault/fault_code/force_flash cleared next cycle; clear_fault in other states ignored.
REQ-025 If a violation persists after clear, MON_INIT SHALL re-fault per REQ-015 on the following cycle.
REQ-026 R->G, R->Y, Y->G, G->Y SHALL be legal transitions.

Reset
REQ-027 rst high at a clk edge SHALL force MON_INIT, fault=0, fault_code=0, force_flash=0, armed=0, dwell counts=0, previous-lamp registers=Y; rst overrides clear_fault and any fault in progress.

Configuration
REQ-028 Macro LIGHT_MON_WATCHDOG_EN defined: check 5 enabled per REQ-019.
REQ-029 Macro undefined: check 5 logic absent, fault_code 5 never produced; all other behaviour identical.

Structure
REQ-030 Package light_mon_pkg SHALL hold lamp code constants R/Y/G, fault code constants, and the state encoding.
REQ-031 Sub-module lamp_dwell (per-lamp previous-code register, change detect, saturating dwell counter) SHALL be instantiated four times.

Verification
REQ-032 Reset, all lamps Y for 1 cycle, then west G others R for 5 ticks -> armed=1 after first Y sample, fault stays 0.
REQ-033 In MON_RUN, west G and north G simultaneously -> fault=1, fault_code=2 next cycle, force_flash=1.
REQ-034 In MON_RUN, east G then R next cycle -> fault_code=3; pulse clear_fault -> fault=0, state MON_INIT, armed=0.
REQ-035 MIN_YELLOW=2: west Y held 1 tick then R -> fault_code=4; same with 2 ticks -> no fault.
REQ-036 Watchdog on, MAX_GREEN=8: south G held for 9 ticks -> fault_code=5 on the 9th tick; macro off -> no fault.
REQ-037 Lamp 11 plus G conflict in the same cycle -> fault_code=1; rst mid-fault -> all outputs 0 next cycle.
